// File: rtl/sti_s4_masker.sv
// rtl/sti_s4_masker.sv - 3-share Boolean masker for S-box input nibbles with output FIFO
// Optional feature macro: STI_S4_LFSR_EN (internal 16-bit LFSR replaces rnd_in)
module sti_s4_masker #(
  parameter int SHARES = 3,
  parameter int DEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  rnd_in,
  input  logic [15:0] seed,
  input  logic        seed_load,
  output logic [11:0] out_shares,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] mask_cnt
);

  localparam int AW = (DEPTH == 4) ? 2 : 1;
  localparam int SW = 4 * SHARES;

  typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;

  state_t        state;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [SW-1:0] mem [DEPTH];
  logic [7:0]    r;
  logic [SW-1:0] shares;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          reload;

`ifdef STI_S4_LFSR_EN
  logic [15:0] lfsr;
  logic        unused_rnd;
  assign unused_rnd = ^rnd_in;
  assign r          = lfsr[7:0];
  assign reload     = seed_load;
`else
  logic unused_seed;
  assign unused_seed = ^{seed, seed_load};
  assign r           = rnd_in;
  assign reload      = 1'b0;
`endif

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // A seed reload in RUN steals the cycle so no transfer sees a half-updated LFSR
  assign in_ready  = (state == RUN) && !full && !reload;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Only masked shares leave this expression; in_data itself is never registered
  assign shares     = {in_data ^ r[3:0] ^ r[7:4], r[7:4], r[3:0]};
  assign out_shares = empty ? 12'h000 : mem[rd_ptr[AW-1:0]];

  // Control FSM, plus LFSR seeding and per-transfer advance when enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
`ifdef STI_S4_LFSR_EN
      lfsr  <= 16'hACE1;
`endif
    end else begin
      case (state)
`ifdef STI_S4_LFSR_EN
        IDLE: state <= SEED;
        SEED: if (seed_load) state <= RUN;
`else
        IDLE: state <= RUN;
        SEED: state <= RUN;
`endif
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase
`ifdef STI_S4_LFSR_EN
      if (seed_load && (state != IDLE)) begin
        lfsr <= seed;
      end else if (push) begin
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      end
`endif
    end
  end

  // FIFO pointers and mask counter; async reset drops buffered shares at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mask_cnt <= 16'h0000;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        mask_cnt <= mask_cnt + 16'h0001;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Share storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= shares;
    end
  end

endmodule
